// File: rtl/ring_buf_pkg.sv
// Shared constants, output-stage state type and filter match set for the ring buffer reader.
package ring_buf_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTR_W  = 4;

  typedef enum logic [0:0] {
    ST_EMPTY,
    ST_HOLD
  } out_state_e;

  localparam logic [DATA_W-1:0] FILT_A = 8'd0;
  localparam logic [DATA_W-1:0] FILT_B = 8'd5;
  localparam logic [DATA_W-1:0] FILT_C = 8'd10;

  function automatic logic is_filtered(input logic [DATA_W-1:0] d);
    return (d == FILT_A) || (d == FILT_B) || (d == FILT_C);
  endfunction

endpackage

// File: rtl/ring_buf_mem.sv
// DEPTH x DATA_W storage array: registered write port, asynchronous read port.
module ring_buf_mem
  import ring_buf_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ring_buffer_reader.sv
// Consumer end of the byte ring buffer: circular store plus registered valid/ready output stage.
// Optional build macro RING_MATCH_FILTER_EN discards pushes of 0x00, 0x05 and 0x0A.
module ring_buffer_reader
  import ring_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              overflow
);

  localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

  out_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] rd_data;
  logic              keep, push, drop, pop, mem_we;

`ifdef RING_MATCH_FILTER_EN
  assign keep = !is_filtered(data_in);
`else
  assign keep = 1'b1;
`endif

  assign full   = (count_q == FullCount);
  // Drop decision uses pre-pop occupancy, so a same-cycle pop never rescues a push.
  assign push   = wr_en && keep && !full;
  assign drop   = wr_en && keep && full;
  assign pop    = (count_q != '0) && ((state_q == ST_EMPTY) || out_ready);
  assign mem_we = push && !clr;

  ring_buf_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;
    if (clr) begin
      state_d    = ST_EMPTY;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      out_data_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        out_data_d = rd_data;
      end
      count_d    = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      overflow_d = overflow_q | drop;
      unique case (state_q)
        ST_EMPTY: if (pop) state_d = ST_HOLD;
        ST_HOLD:  if (out_ready && !pop) state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = (state_q == ST_HOLD);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ring_buffer_reader.sv
// Scoreboard bench for ring_buffer_reader: stimulus queues expected bytes, a monitor checks handshakes.
module tb_ring_buffer_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] data_in;
  logic       clr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ring_buffer_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit expect_store);
    wr_en   = 1'b1;
    data_in = d;
    if (expect_store) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_complete", {31'd0, (exp_q.size() == 0 && !out_valid)}, 32'd1);
  endtask

  // Monitor: handshakes observed between edges are the ones the next rising edge commits.
  initial begin : monitor
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", {31'd0, out_valid}, 32'd1);
          check("stall_data_held", {24'd0, out_data}, {24'd0, prev_data});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_data", {24'd0, out_data}, {24'd0, e});
          end
        end
        prev_stall = out_valid && !out_ready && !clr;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; data_in = '0; clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);

    // Single push latency and hold
    push(8'h3C, 1'b1);
    check("lat_valid_edge1", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_valid_edge2", {31'd0, out_valid}, 32'd1);
    check("lat_data_edge2", {24'd0, out_data}, 32'h3C);
    check("lat_count", {27'd0, count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", {24'd0, out_data}, 32'h3C);
    end
    drain(20);

    // Fill, full and overflow
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
    check("fill_count15", {27'd0, count}, 32'd15);
    check("fill_full0", {31'd0, full}, 32'd0);
    check("fill_head", {24'd0, out_data}, 32'h01);
    push(8'h11, 1'b1);
    check("fill_count16", {27'd0, count}, 32'd16);
    check("fill_full1", {31'd0, full}, 32'd1);
    check("fill_ovf0", {31'd0, overflow}, 32'd0);
    push(8'h12, 1'b0);
    check("drop_ovf1", {31'd0, overflow}, 32'd1);
    check("drop_count", {27'd0, count}, 32'd16);
    drain(60);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", {31'd0, overflow}, 32'd0);

    // Streaming at one byte per cycle across pointer wraps
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(8'(8'h40 + i), 1'b1);
      if (i >= 1) check("stream_valid", {31'd0, out_valid}, 32'd1);
      if (i >= 1) check("stream_count", {27'd0, count}, 32'd1);
    end
    drain(20);
    check("stream_ovf", {31'd0, overflow}, 32'd0);

    // Random back-pressure, pushes gated off while full
    for (int i = 0; i < 150; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && !full) begin
        push(8'(i), 1'b1);
      end else begin
        tick();
      end
    end
    drain(60);
    check("rand_ovf", {31'd0, overflow}, 32'd0);

    // Flush with a concurrent push
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'(8'h80 + i), 1'b1);
    check("pre_clr_count", {27'd0, count}, 32'd8);
    clr = 1'b1; wr_en = 1'b1; data_in = 8'hAA;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    exp_q.delete();
    check("clr_count", {27'd0, count}, 32'd0);
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    check("clr_overflow", {31'd0, overflow}, 32'd0);
    out_ready = 1'b1;
    repeat (10) tick();
    check("post_clr_valid", {31'd0, out_valid}, 32'd0);

    // Match-set filter (or plain acceptance when the filter is not built)
    out_ready = 1'b0;
`ifdef RING_MATCH_FILTER_EN
    push(8'h00, 1'b0);
    push(8'h05, 1'b0);
    push(8'h07, 1'b1);
    push(8'h0A, 1'b0);
    push(8'h0B, 1'b1);
    check("filt_count", {27'd0, count}, 32'd1);
    check("filt_head", {24'd0, out_data}, 32'h07);
`else
    push(8'h00, 1'b1);
    push(8'h05, 1'b1);
    push(8'h07, 1'b1);
    push(8'h0A, 1'b1);
    push(8'h0B, 1'b1);
    check("nofilt_count", {27'd0, count}, 32'd4);
    check("nofilt_head", {24'd0, out_data}, 32'h00);
`endif
    drain(30);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_count", {27'd0, count}, 32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", {24'd0, out_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
